// File: rtl/vector_checker.sv
// Compares a stream of result beats against a preloaded table of expected
// vectors under a bit mask, reporting error count and the first failing beat.
module vector_checker #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [AW:0]      num_vec,
    input  logic [WIDTH-1:0] cmp_mask,
    input  logic             exp_we,
    input  logic [AW-1:0]    exp_addr,
    input  logic [WIDTH-1:0] exp_wdata,
    input  logic             res_valid,
    input  logic [WIDTH-1:0] res_data,
    output logic             res_ready,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [AW:0]      err_count,
    output logic [AW-1:0]    first_fail_idx,
    output logic [WIDTH-1:0] first_fail_data
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_RUN  = 2'd1;
    localparam logic [1:0] S_DONE = 2'd2;

    logic [1:0]       state;
    logic [AW:0]      vec_count;
    logic [WIDTH-1:0] mask;
    logic [AW-1:0]    index;
    logic [WIDTH-1:0] exp_mem [DEPTH];

    logic             accept;
    logic             mismatch;
    logic             last_beat;
    logic [AW:0]      num_clamped;
    logic [AW:0]      err_next;

    assign res_ready = (state == S_RUN);
    assign busy      = (state == S_RUN);
    assign done      = (state == S_DONE);

    always_comb begin
        accept      = res_valid & res_ready;
        mismatch    = |((res_data ^ exp_mem[index]) & mask);
        last_beat   = ({1'b0, index} == (vec_count - (AW+1)'(1)));
        num_clamped = (num_vec > (AW+1)'(DEPTH)) ? (AW+1)'(DEPTH) : num_vec;
        err_next    = err_count + (AW+1)'(mismatch);
    end

    // NOTE: the vector table has no reset; its contents must survive a run abort.
    always_ff @(posedge clk) begin
        if (exp_we && state != S_RUN)
            exp_mem[exp_addr] <= exp_wdata;
    end

    // NOTE: all state uses non-blocking assignments so every register sees
    // pre-edge values of its peers within the same clock.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= S_IDLE;
            vec_count       <= '0;
            mask            <= '0;
            index           <= '0;
            pass            <= 1'b0;
            err_count       <= '0;
            first_fail_idx  <= '0;
            first_fail_data <= '0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        vec_count       <= num_clamped;
                        mask            <= cmp_mask;
                        index           <= '0;
                        err_count       <= '0;
                        first_fail_idx  <= '0;
                        first_fail_data <= '0;
                        if (num_clamped == '0) begin
                            state <= S_DONE;
                            pass  <= 1'b1;
                        end else begin
                            state <= S_RUN;
                            pass  <= 1'b0;
                        end
                    end
                end
                S_RUN: begin
                    if (accept) begin
                        index     <= index + 1'b1;
                        err_count <= err_next;
                        // Only the first mismatch of a run is recorded.
                        if (mismatch && err_count == '0) begin
                            first_fail_idx  <= index;
                            first_fail_data <= res_data;
                        end
                        if (last_beat) begin
                            state <= S_DONE;
                            pass  <= (err_next == '0);
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vector_checker.sv
// Directed testbench for vector_checker: each task drives one scenario and
// compares outputs against hand-computed values.
module tb_vector_checker;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [4:0]  num_vec;
    logic [31:0] cmp_mask;
    logic        exp_we;
    logic [3:0]  exp_addr;
    logic [31:0] exp_wdata;
    logic        res_valid;
    logic [31:0] res_data;
    logic        res_ready;
    logic        busy;
    logic        done;
    logic        pass;
    logic [4:0]  err_count;
    logic [3:0]  first_fail_idx;
    logic [31:0] first_fail_data;

    int checks = 0;
    int errors = 0;

    vector_checker #(.WIDTH(32), .DEPTH(16)) dut (
        .clk             (clk),
        .reset           (reset),
        .start           (start),
        .num_vec         (num_vec),
        .cmp_mask        (cmp_mask),
        .exp_we          (exp_we),
        .exp_addr        (exp_addr),
        .exp_wdata       (exp_wdata),
        .res_valid       (res_valid),
        .res_data        (res_data),
        .res_ready       (res_ready),
        .busy            (busy),
        .done            (done),
        .pass            (pass),
        .err_count       (err_count),
        .first_fail_idx  (first_fail_idx),
        .first_fail_data (first_fail_data)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

    task automatic load_vec(input logic [3:0] addr, input logic [31:0] data);
        @(negedge clk);
        exp_we = 1'b1; exp_addr = addr; exp_wdata = data;
        @(negedge clk);
        exp_we = 1'b0;
    endtask

    // Returns at the negedge after the start edge.
    task automatic drive_start(input logic [4:0] n, input logic [31:0] m);
        @(negedge clk);
        start = 1'b1; num_vec = n; cmp_mask = m;
        @(negedge clk);
        start = 1'b0; num_vec = '0;
    endtask

    task automatic send_beat(input logic [31:0] d);
        @(negedge clk);
        res_valid = 1'b1; res_data = d;
    endtask

    task automatic gap;
        @(negedge clk);
        res_valid = 1'b0; res_data = 32'hDEAD_BEEF;
    endtask

    task automatic end_beats;
        @(negedge clk);
        res_valid = 1'b0; res_data = '0;
    endtask

    task automatic test_reset;
        reset = 1'b0; start = 1'b0; num_vec = '0; cmp_mask = '0;
        exp_we = 1'b0; exp_addr = '0; exp_wdata = '0; res_valid = 1'b0; res_data = '0;
        repeat (3) @(negedge clk);
        checks++; if ({res_ready, busy, done, pass} !== 4'b0000) begin errors++;
            $display("FAIL reset_flags: got %b expected 0000", {res_ready, busy, done, pass}); end
        checks++; if (err_count !== 5'd0) begin errors++;
            $display("FAIL reset_err_count: got %0d expected 0", err_count); end
        checks++; if (first_fail_idx !== 4'd0 || first_fail_data !== 32'd0) begin errors++;
            $display("FAIL reset_first_fail: got idx %0d data %h expected 0 0", first_fail_idx, first_fail_data); end
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({busy, done} !== 2'b00) begin errors++;
            $display("FAIL idle_after_reset: got %b expected 00", {busy, done}); end
        for (int i = 0; i < 16; i++) load_vec(4'(i), 32'((i + 1) * 16));
    endtask

    task automatic test_all_match;
        drive_start(5'd4, 32'hFFFF_FFFF);
        checks++; if (res_ready !== 1'b1 || busy !== 1'b1) begin errors++;
            $display("FAIL match_running: got ready %b busy %b expected 1 1", res_ready, busy); end
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h30); send_beat(32'h40);
        checks++; if (done !== 1'b0) begin errors++;
            $display("FAIL match_done_early: got %b expected 0", done); end
        end_beats();
        checks++; if ({done, pass, busy, res_ready} !== 4'b1100) begin errors++;
            $display("FAIL match_finish: got %b expected 1100", {done, pass, busy, res_ready}); end
        checks++; if (err_count !== 5'd0) begin errors++;
            $display("FAIL match_err_count: got %0d expected 0", err_count); end
    endtask

    task automatic test_mismatch;
        drive_start(5'd4, 32'hFFFF_FFFF);
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h31); send_beat(32'h00);
        end_beats();
        checks++; if (err_count !== 5'd2) begin errors++;
            $display("FAIL mismatch_err_count: got %0d expected 2", err_count); end
        checks++; if (first_fail_idx !== 4'd2) begin errors++;
            $display("FAIL mismatch_first_idx: got %0d expected 2", first_fail_idx); end
        checks++; if (first_fail_data !== 32'h31) begin errors++;
            $display("FAIL mismatch_first_data: got %h expected 00000031", first_fail_data); end
        checks++; if (pass !== 1'b0 || done !== 1'b1) begin errors++;
            $display("FAIL mismatch_pass_done: got pass %b done %b expected 0 1", pass, done); end
        repeat (3) @(negedge clk);
        checks++; if (done !== 1'b1 || err_count !== 5'd2 || first_fail_data !== 32'h31) begin errors++;
            $display("FAIL done_hold: got done %b err %0d data %h expected 1 2 00000031", done, err_count, first_fail_data); end
    endtask

    task automatic test_zero_vectors;
        drive_start(5'd0, 32'hFFFF_FFFF);
        checks++; if ({done, pass, res_ready, busy} !== 4'b1100) begin errors++;
            $display("FAIL zero_finish: got %b expected 1100", {done, pass, res_ready, busy}); end
        checks++; if (err_count !== 5'd0 || first_fail_idx !== 4'd0 || first_fail_data !== 32'd0) begin errors++;
            $display("FAIL zero_results: got err %0d idx %0d data %h expected 0 0 0", err_count, first_fail_idx, first_fail_data); end
        @(negedge clk);
        checks++; if (res_ready !== 1'b0) begin errors++;
            $display("FAIL zero_ready: got %b expected 0", res_ready); end
    endtask

    task automatic test_mask;
        drive_start(5'd4, 32'hFFFF_FFF0);
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h3F); send_beat(32'h40);
        end_beats();
        checks++; if (pass !== 1'b1 || err_count !== 5'd0) begin errors++;
            $display("FAIL mask_pass: got pass %b err %0d expected 1 0", pass, err_count); end
        checks++; if (first_fail_idx !== 4'd0 || first_fail_data !== 32'd0) begin errors++;
            $display("FAIL mask_first_fail: got idx %0d data %h expected 0 0", first_fail_idx, first_fail_data); end
    endtask

    task automatic test_gapped;
        drive_start(5'd4, 32'hFFFF_FFFF);
        send_beat(32'h10); gap(); gap();
        send_beat(32'h20); gap(); gap();
        send_beat(32'h99); gap(); gap();
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL gapped_early: got done %b busy %b expected 0 1", done, busy); end
        send_beat(32'h40);
        end_beats();
        checks++; if (done !== 1'b1 || err_count !== 5'd1) begin errors++;
            $display("FAIL gapped_finish: got done %b err %0d expected 1 1", done, err_count); end
        checks++; if (first_fail_idx !== 4'd2 || first_fail_data !== 32'h99) begin errors++;
            $display("FAIL gapped_first_fail: got idx %0d data %h expected 2 00000099", first_fail_idx, first_fail_data); end
    endtask

    task automatic test_write_in_run;
        drive_start(5'd4, 32'hFFFF_FFFF);
        @(negedge clk);
        exp_we = 1'b1; exp_addr = 4'd1; exp_wdata = 32'hBAD;
        start = 1'b1; num_vec = 5'd0;
        @(negedge clk);
        exp_we = 1'b0; start = 1'b0;
        checks++; if (busy !== 1'b1 || done !== 1'b0) begin errors++;
            $display("FAIL start_in_run: got busy %b done %b expected 1 0", busy, done); end
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h30); send_beat(32'h40);
        end_beats();
        drive_start(5'd4, 32'hFFFF_FFFF);
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h30); send_beat(32'h40);
        end_beats();
        checks++; if (pass !== 1'b1 || err_count !== 5'd0) begin errors++;
            $display("FAIL write_in_run_mem: got pass %b err %0d expected 1 0", pass, err_count); end
    endtask

    task automatic test_clamp;
        drive_start(5'd31, 32'hFFFF_FFFF);
        for (int i = 0; i < 15; i++) send_beat(32'((i + 1) * 16));
        checks++; if (done !== 1'b0 || busy !== 1'b1) begin errors++;
            $display("FAIL clamp_early: got done %b busy %b expected 0 1", done, busy); end
        send_beat(32'h100);
        end_beats();
        checks++; if (done !== 1'b1 || pass !== 1'b1) begin errors++;
            $display("FAIL clamp_finish: got done %b pass %b expected 1 1", done, pass); end
    endtask

    task automatic test_reset_mid_run;
        drive_start(5'd4, 32'hFFFF_FFFF);
        send_beat(32'h10); send_beat(32'h99);
        end_beats();
        checks++; if (err_count !== 5'd1 || busy !== 1'b1) begin errors++;
            $display("FAIL abort_pre: got err %0d busy %b expected 1 1", err_count, busy); end
        #1 reset = 1'b0;
        #1;
        checks++; if ({res_ready, busy, done, pass} !== 4'b0000 || err_count !== 5'd0) begin errors++;
            $display("FAIL abort_outputs: got flags %b err %0d expected 0000 0", {res_ready, busy, done, pass}, err_count); end
        checks++; if (first_fail_idx !== 4'd0 || first_fail_data !== 32'd0) begin errors++;
            $display("FAIL abort_first_fail: got idx %0d data %h expected 0 0", first_fail_idx, first_fail_data); end
        @(negedge clk);
        reset = 1'b1;
        drive_start(5'd4, 32'hFFFF_FFFF);
        send_beat(32'h10); send_beat(32'h20); send_beat(32'h30); send_beat(32'h40);
        end_beats();
        checks++; if (done !== 1'b1 || pass !== 1'b1 || err_count !== 5'd0) begin errors++;
            $display("FAIL abort_rerun: got done %b pass %b err %0d expected 1 1 0", done, pass, err_count); end
    endtask

    initial begin
        test_reset();
        test_all_match();
        test_mismatch();
        test_zero_vectors();
        test_mask();
        test_gapped();
        test_write_in_run();
        test_clamp();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_checker.md
VECTOR_CHECKER -- requirements
Module: vector_checker

Interface
REQ-001 Parameter WIDTH, default 32, bit width of checked results and expected vectors.
REQ-002 Parameter DEPTH, default 16, number of expected-vector entries (power of two); AW = log2(DEPTH).
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 start  input  1  one-cycle request to begin a check run.
REQ-006 num_vec  input  AW+1  vectors in the run, sampled with start; legal range 0..DEPTH.
REQ-007 cmp_mask  input  WIDTH  bit-compare mask, sampled with start; 1 = bit compared.
REQ-008 exp_we  input  1  expected-memory write enable.
REQ-009 exp_addr  input  AW  expected-memory write address.
REQ-010 exp_wdata  input  WIDTH  expected-memory write data.
REQ-011 res_valid  input  1  DUT result beat valid.
REQ-012 res_data  input  WIDTH  DUT result beat.
REQ-013 res_ready  output  1  checker accepts a beat.
REQ-014 busy  output  1  run in progress.
REQ-015 done  output  1  run finished; results stable.
REQ-016 pass  output  1  finished run had zero mismatches.
REQ-017 err_count  output  AW+1  mismatches in current/last run.
REQ-018 first_fail_idx  output  AW  index of first mismatching beat.
REQ-019 first_fail_data  output  WIDTH  res_data of first mismatching beat.

Function
REQ-020 FSM states IDLE, RUN, DONE; reset state IDLE.
REQ-021 Expected memory: DEPTH x WIDTH, synchronous write, asynchronous read at the current beat index.
REQ-022 exp_we honoured in IDLE and DONE; ignored in RUN (memory unchanged).
REQ-023 IDLE/DONE + start=1, num_vec>0: latch num_vec and cmp_mask, clear index, err_count, first_fail_*, done, pass; next state RUN.
REQ-024 IDLE/DONE + start=1, num_vec=0: next state DONE with pass=1, err_count=0.
REQ-025 num_vec>DEPTH treated as DEPTH.
REQ-026 start while in RUN ignored.
REQ-027 res_ready=1 exactly when state is RUN; combinational from state only.
REQ-028 Beat accepted when res_valid & res_ready; no accept otherwise; index holds while res_valid=0.
REQ-029 Accepted beat mismatches when ((res_data ^ exp_mem[index]) & mask) != 0.
REQ-030 Mismatch increments err_count by 1; on first mismatch of the run, capture index into first_fail_idx and res_data into first_fail_data; later mismatches do not overwrite.
REQ-031 Index increments by 1 per accepted beat; on the beat with index = latched num_vec-1, next state DONE.
REQ-032 done and pass registered: both update the cycle after the last accepted beat; pass = (final err_count == 0).
REQ-033 busy=1 in RUN, else 0; done=1 in DONE, else 0.
REQ-034 DONE holds all result outputs until the next accepted start.
REQ-035 first_fail_* values are meaningful only when err_count>0; otherwise 0.

Reset
REQ-036 reset=0 asynchronously forces: state IDLE, res_ready=0, busy=0, done=0, pass=0, err_count=0, first_fail_idx=0, first_fail_data=0, index=0, latched num_vec/mask=0.
REQ-037 Expected-memory contents are not reset.
REQ-038 reset asserted mid-RUN aborts the run; after release block is IDLE and expected memory retains prior contents.

Verification
REQ-039 Load exp[0..3]=0x10,0x20,0x30,0x40; start num_vec=4, mask=0xFFFFFFFF; send identical beats back-to-back -> done and pass=1 on the cycle after beat 3, err_count=0.
REQ-040 Same load; beat 2 = 0x31, beat 3 = 0x00 -> err_count=2, first_fail_idx=2, first_fail_data=0x31, pass=0.
REQ-041 Mask=0xFFFFFFF0, beat 2 = 0x3F -> no mismatch, pass=1.
REQ-042 res_valid gapped (1,0,0,1,...) for num_vec=4 -> exactly 4 beats accepted, index stalls during gaps, done after 4th beat.
REQ-043 start with num_vec=0 -> DONE next cycle, pass=1, res_ready never 1; exp_we during RUN leaves memory unchanged (read back on next run).
REQ-044 reset=0 after 2 of 4 beats -> all outputs 0 immediately; after release, new run with stored vectors passes.
